// File: rtl/mer_arb.sv
// Two-input round-robin packet arbiter for the Mer merge unit.
// Each channel has a 2-entry buffer; heads and the select flag feed PktSel directly.
module mer_arb #(
  parameter int PKT_W = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i_merarb,
  input  logic             rst_i_merarb,
  input  logic             req_pkta_i_merarb,
  input  logic [PKT_W-1:0] pkta_i_merarb,
  output logic             ack_pkta_o_merarb,
  input  logic             req_pktb_i_merarb,
  input  logic [PKT_W-1:0] pktb_i_merarb,
  output logic             ack_pktb_o_merarb,
  output logic [PKT_W-1:0] pkta_o_merarb,
  output logic [PKT_W-1:0] pktb_o_merarb,
  output logic             aeb_o_merarb,
  output logic             req_o_merarb,
  input  logic             ack_i_merarb
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PKT_W-1:0] mem_a_r [2];
  logic [PKT_W-1:0] mem_b_r [2];
  logic [CNT_W-1:0] cnt_a_r, cnt_b_r, cnt_a_nxt_s, cnt_b_nxt_s;
  logic             wr_a_r, rd_a_r, wr_b_r, rd_b_r;
  logic             ack_a_r, ack_b_r;
  logic             lock_r, lock_sel_r, last_r;
  logic             push_a_s, push_b_s, pop_s, pop_a_s, pop_b_s;
  logic             ne_a_s, ne_b_s, req_s, sel_s;

  assign push_a_s = req_pkta_i_merarb & ack_a_r;
  assign push_b_s = req_pktb_i_merarb & ack_b_r;
  assign ne_a_s   = (cnt_a_r != {CNT_W{1'b0}});
  assign ne_b_s   = (cnt_b_r != {CNT_W{1'b0}});
  assign req_s    = ne_a_s | ne_b_s;
  assign pop_s    = req_s & ack_i_merarb;
  assign pop_a_s  = pop_s & ~sel_s;
  assign pop_b_s  = pop_s & sel_s;

  // Select flag: a held decision wins, otherwise the non-empty channel, ties alternate.
  always_comb begin
    sel_s = 1'b0;
    if (lock_r) begin
      sel_s = lock_sel_r;
    end else if (ne_a_s && !ne_b_s) begin
      sel_s = 1'b0;
    end else if (!ne_a_s && ne_b_s) begin
      sel_s = 1'b1;
    end else if (ne_a_s && ne_b_s) begin
      sel_s = ~last_r;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next-state occupancy per channel; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_a_nxt_s = cnt_a_r;
    cnt_b_nxt_s = cnt_b_r;
    case ({push_a_s, pop_a_s})
      2'b10:   cnt_a_nxt_s = cnt_a_r + CNT_W'(1);
      2'b01:   cnt_a_nxt_s = cnt_a_r - CNT_W'(1);
      default: cnt_a_nxt_s = cnt_a_r;
    endcase
    case ({push_b_s, pop_b_s})
      2'b10:   cnt_b_nxt_s = cnt_b_r + CNT_W'(1);
      2'b01:   cnt_b_nxt_s = cnt_b_r - CNT_W'(1);
      default: cnt_b_nxt_s = cnt_b_r;
    endcase
  end

  // Control state: counts, pointers, input acks and the lock/round-robin bits.
  always_ff @(posedge clk_i_merarb) begin
    if (rst_i_merarb) begin
      cnt_a_r    <= {CNT_W{1'b0}};
      cnt_b_r    <= {CNT_W{1'b0}};
      wr_a_r     <= 1'b0;
      rd_a_r     <= 1'b0;
      wr_b_r     <= 1'b0;
      rd_b_r     <= 1'b0;
      ack_a_r    <= 1'b1;
      ack_b_r    <= 1'b1;
      lock_r     <= 1'b0;
      lock_sel_r <= 1'b0;
      last_r     <= 1'b1;
    end else begin
      cnt_a_r <= cnt_a_nxt_s;
      cnt_b_r <= cnt_b_nxt_s;
      ack_a_r <= (cnt_a_nxt_s < FULL_CNT);
      ack_b_r <= (cnt_b_nxt_s < FULL_CNT);
      if (push_a_s) wr_a_r <= ~wr_a_r;
      if (pop_a_s)  rd_a_r <= ~rd_a_r;
      if (push_b_s) wr_b_r <= ~wr_b_r;
      if (pop_b_s)  rd_b_r <= ~rd_b_r;
      if (pop_s) begin
        lock_r <= 1'b0;
        last_r <= sel_s;
      end else if (req_s) begin
        // Downstream stalled: freeze the choice until it is accepted.
        lock_r     <= 1'b1;
        lock_sel_r <= sel_s;
      end
    end
  end

  // Packet storage; no reset needed since pointers and counts define validity.
  always_ff @(posedge clk_i_merarb) begin
    if (push_a_s) mem_a_r[wr_a_r] <= pkta_i_merarb;
    if (push_b_s) mem_b_r[wr_b_r] <= pktb_i_merarb;
  end

  assign pkta_o_merarb     = mem_a_r[rd_a_r];
  assign pktb_o_merarb     = mem_b_r[rd_b_r];
  assign aeb_o_merarb      = sel_s;
  assign req_o_merarb      = req_s;
  assign ack_pkta_o_merarb = ack_a_r;
  assign ack_pktb_o_merarb = ack_b_r;

endmodule

// File: tb/tb_mer_arb.sv
// Scoreboard bench for mer_arb: directed stimulus queues expected {aeb, packet};
// a negedge monitor pops and compares on every output transfer.
module tb_mer_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, ack_i;
  logic [63:0] pkta_in, pktb_in;
  logic        ack_a, ack_b, aeb, req_o;
  logic [63:0] pkta_out, pktb_out;

  logic [64:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mer_arb #(.PKT_W(64), .DEPTH(2)) dut (
    .clk_i_merarb      (clk),
    .rst_i_merarb      (rst),
    .req_pkta_i_merarb (req_a),
    .pkta_i_merarb     (pkta_in),
    .ack_pkta_o_merarb (ack_a),
    .req_pktb_i_merarb (req_b),
    .pktb_i_merarb     (pktb_in),
    .ack_pktb_o_merarb (ack_b),
    .pkta_o_merarb     (pkta_out),
    .pktb_o_merarb     (pktb_out),
    .aeb_o_merarb      (aeb),
    .req_o_merarb      (req_o),
    .ack_i_merarb      (ack_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic sel, input logic [63:0] pkt);
    exp_q.push_back({sel, pkt});
  endtask

  // Wait for all queued packets to leave, then require the output to go idle.
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk("idle_req", {63'd0, req_o}, 64'd0);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && req_o === 1'b1 && ack_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got aeb=%b pkt=%h, expected none", aeb,
                 aeb ? pktb_out : pkta_out);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("out_aeb", {63'd0, aeb}, {63'd0, e[64]});
        chk("out_pkt", aeb ? pktb_out : pkta_out, e[63:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ack_i = 1'b0;
    pkta_in = 64'd0; pktb_in = 64'd0;
    step(); step();
    @(negedge clk);
    chk("rst_ack_a", {63'd0, ack_a}, 64'd1);
    chk("rst_ack_b", {63'd0, ack_b}, 64'd1);
    chk("rst_req",   {63'd0, req_o}, 64'd0);
    chk("rst_aeb",   {63'd0, aeb},   64'd0);
    step();
    rst = 1'b0;

    // Single packet, one-cycle latency
    ack_i = 1'b1; req_a = 1'b1; pkta_in = 64'h1;
    expect_out(1'b0, 64'h1);
    step();
    req_a = 1'b0;
    @(negedge clk);
    chk("t1_req", {63'd0, req_o}, 64'd1);
    chk("t1_aeb", {63'd0, aeb},   64'd0);
    step();
    @(negedge clk);
    chk("t1_req_after", {63'd0, req_o}, 64'd0);

    // Lock: A was served last, so without the lock B would win the tie
    step();
    ack_i = 1'b0; req_a = 1'b1; pkta_in = 64'hA0;
    expect_out(1'b0, 64'hA0);
    expect_out(1'b1, 64'hB0);
    step();
    req_a = 1'b0; req_b = 1'b1; pktb_in = 64'hB0;
    @(negedge clk);
    chk("t3_aeb0", {63'd0, aeb}, 64'd0);
    step();
    req_b = 1'b0;
    @(negedge clk);
    chk("t3_aeb1", {63'd0, aeb}, 64'd0);
    chk("t3_req",  {63'd0, req_o}, 64'd1);
    step();
    @(negedge clk);
    chk("t3_aeb2", {63'd0, aeb}, 64'd0);
    step();
    ack_i = 1'b1;
    drain(20);

    // Full channel: third push while full is refused
    step();
    ack_i = 1'b0; req_a = 1'b1; pkta_in = 64'hC0;
    expect_out(1'b0, 64'hC0);
    expect_out(1'b0, 64'hC1);
    @(negedge clk);
    chk("t4_ack_p0", {63'd0, ack_a}, 64'd1);
    step();
    pkta_in = 64'hC1;
    @(negedge clk);
    chk("t4_ack_p1", {63'd0, ack_a}, 64'd1);
    step();
    pkta_in = 64'hC2;
    @(negedge clk);
    chk("t4_ack_p2", {63'd0, ack_a}, 64'd0);
    step();
    req_a = 1'b0;
    @(negedge clk);
    chk("t4_ack_hold", {63'd0, ack_a}, 64'd0);
    chk("t4_req",      {63'd0, req_o}, 64'd1);
    step();
    ack_i = 1'b1;
    drain(20);

    // Streaming on A alone at one packet per cycle
    step();
    ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_a = 1'b1;
      pkta_in = 64'h5000 + 64'(i);
      expect_out(1'b0, 64'h5000 + 64'(i));
      @(negedge clk);
      chk("t5_ack_a", {63'd0, ack_a}, 64'd1);
      step();
    end
    req_a = 1'b0;
    drain(20);

    // Reset with both channels full discards everything; A then wins the tie
    step();
    ack_i = 1'b0; req_a = 1'b1; req_b = 1'b1;
    pkta_in = 64'hD0; pktb_in = 64'hE0;
    step();
    pkta_in = 64'hD1; pktb_in = 64'hE1;
    step();
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    chk("t6_full_a", {63'd0, ack_a}, 64'd0);
    chk("t6_full_b", {63'd0, ack_b}, 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req",   {63'd0, req_o}, 64'd0);
    chk("t6_ack_a", {63'd0, ack_a}, 64'd1);
    chk("t6_ack_b", {63'd0, ack_b}, 64'd1);
    chk("t6_aeb",   {63'd0, aeb},   64'd0);
    step();
    ack_i = 1'b1; req_a = 1'b1; req_b = 1'b1;
    pkta_in = 64'hF0; pktb_in = 64'h60;
    expect_out(1'b0, 64'hF0);
    expect_out(1'b1, 64'h60);
    step();
    req_a = 1'b0; req_b = 1'b0;
    drain(20);

    // Two on each channel, output alternates A0 B0 A1 B1
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; ack_i = 1'b1; req_a = 1'b1; req_b = 1'b1;
    pkta_in = 64'hAAA0; pktb_in = 64'hBBB0;
    expect_out(1'b0, 64'hAAA0);
    expect_out(1'b1, 64'hBBB0);
    expect_out(1'b0, 64'hAAA1);
    expect_out(1'b1, 64'hBBB1);
    step();
    pkta_in = 64'hAAA1; pktb_in = 64'hBBB1;
    step();
    req_a = 1'b0; req_b = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mer_arb.md
# mer_arb

Two-input packet arbiter for the merge (Mer) unit of CUES. Each input channel has a 2-deep packet buffer. When both channels hold packets, the block picks one round-robin. It drives the head packet of each channel plus the select flag straight into the packet selector (`PktSel`), which muxes them onto the Mer output. The select decision is held stable until the downstream stage acknowledges, and the chosen packet is then popped.

## Interface
Parameters:
- `PKT_W`, 64: packet width. Packing from MSB: `lr`[63], `node`[62:47], `gen`[46:35], `opr`[34:3], `uni_opr`[2], `mem_wen`[1:0].
- `DEPTH`, 2: entries per channel buffer. Fixed at 2; other values are not supported.

Ports:
- `clk_i_merarb`, in, 1: the single clock. All state changes on its rising edge.
- `rst_i_merarb`, in, 1: synchronous, active-high reset.
- `req_pkta_i_merarb`, in, 1: channel A packet valid.
- `pkta_i_merarb`, in, PKT_W: channel A packet.
- `ack_pkta_o_merarb`, out, 1: channel A ready. Registered, high when A holds fewer than 2 packets.
- `req_pktb_i_merarb`, in, 1: channel B packet valid.
- `pktb_i_merarb`, in, PKT_W: channel B packet.
- `ack_pktb_o_merarb`, out, 1: channel B ready. Registered, same rule as A.
- `pkta_o_merarb`, out, PKT_W: head packet of channel A, to `PktSel`. Value is don't-care when A is empty.
- `pktb_o_merarb`, out, PKT_W: head packet of channel B, to `PktSel`. Value is don't-care when B is empty.
- `aeb_o_merarb`, out, 1: select flag to `PktSel`. 1 selects B, 0 selects A.
- `req_o_merarb`, out, 1: output packet valid.
- `ack_i_merarb`, in, 1: downstream accepts the selected packet.

## Operation
- Input transfer on a channel: req & ack high in the same cycle. The packet is written at the buffer tail and the channel count increments.
- Output transfer: `req_o_merarb` & `ack_i_merarb` high in the same cycle. The selected channel's head is popped and its count decrements.
- A channel can push and pop in the same cycle. Its count is then unchanged, and the write goes to the slot after the popped head.
- `ack_pkt*_o_merarb` is registered from the next-state count: next count < 2. It has no combinational path from `ack_i_merarb`.
- `req_o_merarb` = count_a != 0 | count_b != 0.
- Select when not locked:
  - Only A non-empty: select A.
  - Only B non-empty: select B.
  - Both non-empty: select the channel that was not served last, using the `last` bit (0 means A was served last).
- Lock: if `req_o_merarb` is high and `ack_i_merarb` is low, register the current select and set `lock`. While `lock` is set, `aeb_o_merarb` equals the locked value even if the other channel fills.
- On an output transfer: clear `lock` and set `last` to the served channel.
- Buffer pointers: 1-bit read and write pointers per channel, wrapping 1 -> 0.
- The block never drops or duplicates a packet and never reorders packets within a channel.
- Requests are ignored while the matching ack is low, and data on an ignored request is not written.

## Timing
- Reset values: counts 0, pointers 0, `lock` 0, `last` 1, so A wins the first tie.
- Outputs during and after reset: `ack_pkta_o_merarb` = `ack_pktb_o_merarb` = 1, `req_o_merarb` = 0, `aeb_o_merarb` = 0.
- Latency: a packet accepted at edge N appears at `pkt*_o_merarb` with `req_o_merarb` high in cycle N+1. Minimum input-to-output latency is 1 cycle.
- Throughput: 1 packet per cycle total. A single channel alone also sustains 1 packet per cycle, because the 2-deep buffer plus the registered ack allows a streaming push and pop.
- Full channel: ack drops the cycle after the count reaches 2. If a pop happens in the same cycle as the push that fills it, ack stays high.
- Empty: when both counts are 0, `req_o_merarb` = 0 and `aeb_o_merarb` = 0.
- Reset asserted mid-operation: all buffered packets are discarded at that edge, and outputs return to their reset values the following cycle.

## Test plan
- Reset, then push A = 64'h1 at cycle 2 with `ack_i_merarb` high -> `req_o_merarb` = 1 and `aeb_o_merarb` = 0 in cycle 3; pop in cycle 3; `req_o_merarb` = 0 in cycle 4.
- Fill both channels with A = {A0, A1} and B = {B0, B1}, holding `ack_i_merarb` high -> output order A0, B0, A1, B1 with `aeb_o_merarb` sequence 0, 1, 0, 1.
- A only holds A0 with `ack_i_merarb` low for 3 cycles, and B0 arrives during that time -> `aeb_o_merarb` stays 0. After ack, A0 leaves, then B0 with `aeb_o_merarb` = 1.
- Push A for 3 consecutive cycles with `ack_i_merarb` low -> `ack_pkta_o_merarb` = 0 after the 2nd push. The 3rd request is not accepted and the count stays 2.
- Stream A continuously with `ack_i_merarb` = 1 for 10 cycles -> 10 packets out in order, and `ack_pkta_o_merarb` never drops.
- Assert reset for one cycle with both channels full -> next cycle `req_o_merarb` = 0, both input acks = 1, and the next tie is won by A.
